// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcodes, FSM state encoding and opcode classification for
//                the sequential ALU.
//  Revision    : 1.0
// ============================================================================
package alu_pkg;

    // Opcodes. 0, 14 and 15 are not assigned and are reported as invalid.
    localparam logic [3:0] c_OP_ADD = 4'd1;
    localparam logic [3:0] c_OP_ADC = 4'd2;
    localparam logic [3:0] c_OP_SUB = 4'd3;
    localparam logic [3:0] c_OP_INC = 4'd4;
    localparam logic [3:0] c_OP_DEC = 4'd5;
    localparam logic [3:0] c_OP_AND = 4'd6;
    localparam logic [3:0] c_OP_NOT = 4'd7;
    localparam logic [3:0] c_OP_ROL = 4'd8;
    localparam logic [3:0] c_OP_ROR = 4'd9;
    localparam logic [3:0] c_OP_SBB = 4'd10;
    localparam logic [3:0] c_OP_OR  = 4'd11;
    localparam logic [3:0] c_OP_XOR = 4'd12;
    localparam logic [3:0] c_OP_MUL = 4'd13;

    // Controller states
    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_EXEC = 3'd1;
    localparam logic [2:0] c_S_ROT  = 3'd2;
    localparam logic [2:0] c_S_MUL  = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    // Rotates and multiply take more than one execute cycle; everything else
    // (including invalid opcodes) completes in a single cycle.
    function automatic logic is_multi_cycle(input logic [3:0] op);
        return (op == c_OP_ROL) || (op == c_OP_ROR) || (op == c_OP_MUL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_shift_add.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_shift_add
//  Description : Unsigned shift-add multiplier, one partial product per
//                cycle. o_done is high for one cycle once the product is
//                complete, BUS_WIDTH cycles after i_start.
//  Revision    : 1.0
// ============================================================================
module alu_mul_shift_add #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [BUS_WIDTH-1:0]     i_a,
    input  logic [BUS_WIDTH-1:0]     i_b,
    output logic                     o_done,
    output logic [2*BUS_WIDTH-1:0]   o_product
);

    localparam int c_CNT_W = $clog2(BUS_WIDTH) + 1;

    logic                   r_busy;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [BUS_WIDTH-1:0]   r_mcand;
    logic [2*BUS_WIDTH-1:0] r_acc;     // {partial sum, remaining multiplier}
    logic [BUS_WIDTH:0]     w_step_sum;

    // Add the multiplicand to the upper half when the current multiplier bit is set
    always_comb begin
        w_step_sum = {1'b0, r_acc[2*BUS_WIDTH-1:BUS_WIDTH]};
        if (r_acc[0]) begin
            w_step_sum = w_step_sum + {1'b0, r_mcand};
        end
    end

    // Shift the accumulator right by one per step, retiring one multiplier bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= c_CNT_W'(BUS_WIDTH);
            r_mcand <= i_a;
            r_acc   <= {{BUS_WIDTH{1'b0}}, i_b};
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_acc <= {w_step_sum, r_acc[BUS_WIDTH-1:1]};
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_done    = r_busy && (r_cnt == '0);
    assign o_product = r_acc;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Clocked, handshaked ALU with a persistent carry/borrow flag,
//                bit-serial rotates and a shift-add multiply. One operation
//                in flight at a time; results held until the next done.
//  Revision    : 1.0
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int SHAMT_W   = $clog2(BUS_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 ready,
    input  logic [3:0]           opcode,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic                 carry_clr,
    output logic [BUS_WIDTH-1:0] y,
    output logic [BUS_WIDTH-1:0] y_hi,
    output logic                 done,
    output logic                 carry_out,
    output logic                 borrow,
    output logic                 zero,
    output logic                 parity,
    output logic                 invalid_op,
    output logic                 carry_flag
);

    localparam logic [BUS_WIDTH:0] c_ONE = {{BUS_WIDTH{1'b0}}, 1'b1};

    logic [2:0]             r_state;
    logic [3:0]             r_op;
    logic [BUS_WIDTH-1:0]   r_a;
    logic [BUS_WIDTH-1:0]   r_b;
    logic                   r_cin;
    logic [BUS_WIDTH-1:0]   r_rot;
    logic [SHAMT_W-1:0]     r_rot_cnt;

    logic [BUS_WIDTH-1:0]   r_y;
    logic [BUS_WIDTH-1:0]   r_y_hi;
    logic                   r_carry_out;
    logic                   r_borrow;
    logic                   r_zero;
    logic                   r_parity;
    logic                   r_invalid;
    logic                   r_carry_flag;

    logic                   w_accept;
    logic                   w_finish;
    logic                   w_mul_start;
    logic                   w_mul_done;
    logic [2*BUS_WIDTH-1:0] w_product;
    logic [BUS_WIDTH:0]     w_arith;
    logic [BUS_WIDTH-1:0]   w_y;
    logic [BUS_WIDTH-1:0]   w_y_hi;
    logic                   w_cout;
    logic                   w_bor;
    logic                   w_inv;

    // DONE behaves as idle for handshaking so back-to-back ops are accepted
    assign ready       = (r_state == c_S_IDLE) || (r_state == c_S_DONE);
    assign w_accept    = start && ready;
    assign w_mul_start = w_accept && (opcode == c_OP_MUL);
    assign w_finish    = (r_state == c_S_EXEC)
                      || ((r_state == c_S_ROT) && (r_rot_cnt == '0))
                      || ((r_state == c_S_MUL) && w_mul_done);

    alu_mul_shift_add #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (reset),
        .i_start   (w_mul_start),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // Result selection from the latched operation, consumed on the finishing edge
    always_comb begin
        w_arith = '0;
        w_y     = '0;
        w_y_hi  = '0;
        w_cout  = 1'b0;
        w_bor   = 1'b0;
        w_inv   = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_arith = {1'b0, r_a} + {1'b0, r_b};
                w_y = w_arith[BUS_WIDTH-1:0];  w_cout = w_arith[BUS_WIDTH];
            end
            c_OP_ADC: begin
                w_arith = {1'b0, r_a} + {1'b0, r_b} + {{BUS_WIDTH{1'b0}}, r_cin};
                w_y = w_arith[BUS_WIDTH-1:0];  w_cout = w_arith[BUS_WIDTH];
            end
            c_OP_INC: begin
                w_arith = {1'b0, r_a} + c_ONE;
                w_y = w_arith[BUS_WIDTH-1:0];  w_cout = w_arith[BUS_WIDTH];
            end
            c_OP_SUB: begin
                w_arith = {1'b0, r_a} - {1'b0, r_b};
                w_y = w_arith[BUS_WIDTH-1:0];  w_bor = w_arith[BUS_WIDTH];
            end
            c_OP_SBB: begin
                w_arith = {1'b0, r_a} - {1'b0, r_b} - {{BUS_WIDTH{1'b0}}, r_cin};
                w_y = w_arith[BUS_WIDTH-1:0];  w_bor = w_arith[BUS_WIDTH];
            end
            c_OP_DEC: begin
                w_arith = {1'b0, r_a} - c_ONE;
                w_y = w_arith[BUS_WIDTH-1:0];  w_bor = w_arith[BUS_WIDTH];
            end
            c_OP_AND: w_y = r_a & r_b;
            c_OP_NOT: w_y = ~r_a;
            c_OP_OR:  w_y = r_a | r_b;
            c_OP_XOR: w_y = r_a ^ r_b;
            c_OP_ROL,
            c_OP_ROR: w_y = r_rot;
            c_OP_MUL: {w_y_hi, w_y} = w_product;
            default:  w_inv = 1'b1;
        endcase
    end

    // Control FSM: accept, route to execute/rotate/multiply, then DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cin     <= 1'b0;
            r_rot     <= '0;
            r_rot_cnt <= '0;
        end else begin
            case (r_state)
                c_S_IDLE,
                c_S_DONE: begin
                    if (w_accept) begin
                        r_op      <= opcode;
                        r_a       <= a;
                        r_b       <= b;
                        // A clear in the accept cycle forces a zero carry-in
                        r_cin     <= r_carry_flag && !carry_clr;
                        r_rot     <= a;
                        r_rot_cnt <= b[SHAMT_W-1:0];
                        if (!is_multi_cycle(opcode)) begin
                            r_state <= c_S_EXEC;
                        end else if (opcode == c_OP_MUL) begin
                            r_state <= c_S_MUL;
                        end else begin
                            r_state <= c_S_ROT;
                        end
                    end else begin
                        r_state <= c_S_IDLE;
                    end
                end
                c_S_EXEC: r_state <= c_S_DONE;
                c_S_ROT: begin
                    if (r_rot_cnt == '0) begin
                        r_state <= c_S_DONE;
                    end else begin
                        if (r_op == c_OP_ROR) begin
                            r_rot <= {r_rot[0], r_rot[BUS_WIDTH-1:1]};
                        end else begin
                            r_rot <= {r_rot[BUS_WIDTH-2:0], r_rot[BUS_WIDTH-1]};
                        end
                        r_rot_cnt <= r_rot_cnt - 1'b1;
                    end
                end
                c_S_MUL: begin
                    if (w_mul_done) begin
                        r_state <= c_S_DONE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Result registers load only on the edge that enters DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y         <= '0;
            r_y_hi      <= '0;
            r_carry_out <= 1'b0;
            r_borrow    <= 1'b0;
            r_zero      <= 1'b0;
            r_parity    <= 1'b0;
            r_invalid   <= 1'b0;
        end else if (w_finish) begin
            r_y         <= w_y;
            r_y_hi      <= w_y_hi;
            r_carry_out <= w_cout;
            r_borrow    <= w_bor;
            r_zero      <= (w_y == '0);
            r_parity    <= ^w_y;
            r_invalid   <= w_inv;
        end
    end

    // Architectural carry flag: clear wins over the completion update
    always_ff @(posedge clk) begin
        if (reset || carry_clr) begin
            r_carry_flag <= 1'b0;
        end else if (w_finish) begin
            if ((r_op == c_OP_ADD) || (r_op == c_OP_ADC) || (r_op == c_OP_INC)) begin
                r_carry_flag <= w_cout;
            end else if ((r_op == c_OP_SUB) || (r_op == c_OP_SBB) || (r_op == c_OP_DEC)) begin
                r_carry_flag <= w_bor;
            end
        end
    end

    assign done       = (r_state == c_S_DONE);
    assign y          = r_y;
    assign y_hi       = r_y_hi;
    assign carry_out  = r_carry_out;
    assign borrow     = r_borrow;
    assign zero       = r_zero;
    assign parity     = r_parity;
    assign invalid_op = r_invalid;
    assign carry_flag = r_carry_flag;

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Clocked, handshaked successor to the combinational ALU. Parametrised width; registered result and flags.
- Adds a persistent carry/borrow flag register, so ADC/SBB can chain multi-word arithmetic.
- Adds multi-cycle rotate-by-N and a shift-add multiply.
- Sits between the datapath register file and the writeback stage; one operation in flight at a time.

Parameters:
- BUS_WIDTH, 8, operand/result width. Must be a power of 2, at least 4.
- SHAMT_W, $clog2(BUS_WIDTH), derived rotate-amount width. Not to be overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  high in IDLE; low while an operation is in flight
- opcode  in  4  operation select, sampled on accept
- a  in  BUS_WIDTH  operand A, sampled on accept
- b  in  BUS_WIDTH  operand B, sampled on accept
- carry_clr  in  1  clears carry_flag
- y  out  BUS_WIDTH  result (low half for MUL)
- y_hi  out  BUS_WIDTH  MUL high half; 0 for all other ops
- done  out  1  one-cycle pulse; y, y_hi and flags are valid from this cycle on
- carry_out  out  1  carry from ADD/ADC/INC
- borrow  out  1  borrow from SUB/SBB/DEC
- zero  out  1  y == 0
- parity  out  1  XOR of the bits of y
- invalid_op  out  1  opcode not in the table below
- carry_flag  out  1  architectural carry/borrow flag

Behaviour:
- Reset: state IDLE; ready=1; every other output 0; carry_flag=0. Reset mid-operation aborts with no done pulse.
- Opcodes:
  - 1 ADD: a+b
  - 2 ADC: a+b+carry_flag
  - 3 SUB: a-b
  - 4 INC: a+1
  - 5 DEC: a-1
  - 6 AND
  - 7 NOT a
  - 8 ROL: rotate a left by b[SHAMT_W-1:0]
  - 9 ROR: rotate a right by b[SHAMT_W-1:0]
  - 10 SBB: a-b-carry_flag
  - 11 OR
  - 12 XOR
  - 13 MUL: unsigned a*b, 2*BUS_WIDTH-bit product split as {y_hi,y}
  - 0, 14, 15: invalid
- Accept: start && ready at edge N latches opcode, a, b and the current carry_flag.
- States:
  - IDLE -> EXEC for single-cycle ops and invalid opcodes.
  - IDLE -> ROT for ROL/ROR.
  - IDLE -> MUL for MUL.
  - EXEC/ROT/MUL -> DONE -> IDLE.
- Latency, counted from the accept edge to done=1:
  - single-cycle ops: 1 cycle
  - ROL/ROR: 1+k cycles, k = rotate amount; k=0 costs 1 cycle
  - MUL: 1+BUS_WIDTH cycles
- ready goes low the cycle after accept and returns high in the cycle done is asserted. A back-to-back start in that cycle is accepted.
- start while ready=0 is ignored; no queuing.
- ROT: rotates one bit per cycle; a down-counter of SHAMT_W bits tracks the remaining amount.
- MUL: shift-add, one partial product per cycle; 2*BUS_WIDTH accumulator.
- Result registers (y, y_hi, carry_out, borrow, zero, parity, invalid_op) update only in the done cycle and hold until the next done.
- carry_out/borrow: only the bit relevant to the op may be 1; all other ops drive both to 0.
- carry_flag update at done:
  - set to carry_out after ADD/ADC/INC
  - set to borrow after SUB/SBB/DEC
  - unchanged by all other ops, including invalid
- carry_clr:
  - Clears carry_flag on the next edge.
  - If asserted in the accept cycle of ADC/SBB, the op uses carry 0.
  - If asserted in a done cycle, it takes priority over the flag update.
- Invalid opcode: done after 1 cycle with invalid_op=1, y=y_hi=0, carry_out=borrow=0, zero=1, parity=0.
- zero and parity are computed from the y being registered and are registered with it.

Decomposition:
- Package alu_pkg: opcode localparams, state encoding (IDLE, EXEC, ROT, MUL, DONE), and a function classifying opcodes as single-cycle or multi-cycle.
- One sub-module, alu_mul_shift_add: start/done handshake, parametrised BUS_WIDTH, 2*BUS_WIDTH-bit product.
- The top level owns the FSM, rotate counter, flag register and result registers.

Test Plan:
- ADD a=9, b=33 -> done 1 cycle after accept; y=42, carry_out=0, zero=0, parity=1, carry_flag=0.
- Carry chain:
  - ADD a=200, b=100 -> y=44, carry_out=1, carry_flag=1.
  - Then ADC a=1, b=2 -> y=4, carry_flag=0.
  - Repeat with carry_clr pulsed before the ADC -> y=3.
- Borrow chain:
  - SUB a=65, b=66 -> y=255, borrow=1.
  - Then SBB a=10, b=3 -> y=6, borrow=0.
  - DEC a=0 -> y=255, borrow=1.
- ROL a=0x81, b=3 -> y=0x0C, done 4 cycles after accept, ready=0 in between.
  - A start pulse mid-operation is ignored.
  - ROR a=0x80, b=0 -> y=0x80 after 1 cycle.
- MUL a=200, b=3 -> {y_hi,y}=0x0258, done 9 cycles after accept.
  - MUL 255*255 -> 0xFE01.
  - MUL a=0 -> zero=1.
- Invalid and reset:
  - opcode=15 -> invalid_op=1, y=0, carry_flag unchanged.
  - reset asserted mid-MUL -> no done pulse, ready=1 and all outputs 0 the cycle after reset deasserts.
  - Next ADD completes normally.
